// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, clog2 helper, default byte width.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_t;

  // Minimum of 1 so single-bit indices stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational masked round-robin: lowest request at or above rr_ptr wins, else lowest overall.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               any
);

  logic hit;

  always_comb begin
    grant = '0;
    index = '0;
    hit   = 1'b0;
    any   = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i] && (i >= int'(rr_ptr))) begin
        hit      = 1'b1;
        index    = IW'(i);
        grant[i] = 1'b1;
      end
    end
    // Nothing at or above the pointer: wrap to the lowest request.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req[i]) begin
        hit      = 1'b1;
        index    = IW'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers, one byte in flight at a time.
// Optional per-byte watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_BITS      = DEFAULT_DATA_BITS,
  parameter  int TIMEOUT_CYCLES = 2000000,
  localparam int IW             = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         data_out,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [IW-1:0]                grant_id,
  output logic                         active,
  output logic                         timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 accept;
  logic                 wd_expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .index  (arb_idx),
    .any    (arb_any)
  );

  // rst gates the accept so no ready pulse leaks out while reset is held.
  assign accept      = (state == IDLE) && tx_en && arb_any && !tx_busy && !rst;
  assign req_ready   = accept ? arb_grant : '0;
  assign tx_start    = (state == START);
  assign active      = (state != IDLE);
  assign timeout_err = wd_expire && !tx_done;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wd_cnt;
  logic          in_wait;

  assign in_wait   = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign wd_expire = in_wait && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == START) begin
      wd_cnt <= '0;
    end else if (in_wait) begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = LOAD;
      LOAD:      state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      // A done seen before busy means uart_tx already finished the byte.
      WAIT_BUSY: begin
        if (tx_done)        state_nxt = IDLE;
        else if (wd_expire) state_nxt = IDLE;
        else if (tx_busy)   state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done || wd_expire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      data_out <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_out <= req_data[int'(arb_idx)*DATA_BITS +: DATA_BITS];
        grant_id <= arb_idx;
      end
      if (state == LOAD) begin
        rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small behavioural uart_tx handshake model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic        clk, rst, tx_en;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, tx_done, active, timeout_err;
  logic [7:0]  data_out;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .data_out(data_out), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  typedef struct { logic [7:0] data; logic [1:0] id; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, n_acc = 0, n_start = 0, n_to = 0, last_start = 0;
  bit   model_off = 0, done_first = 0, to_allowed = 0;
  int   busy_len = 3;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // uart_tx model: busy for busy_len+1 cycles then a one-cycle done, or done straight away.
  initial begin
    logic st;
    int   mstage, mleft;
    tx_busy = 0; tx_done = 0; mstage = 0; mleft = 0;
    forever begin
      @(negedge clk); st = tx_start;
      @(posedge clk); #1;
      if (rst || model_off) begin
        tx_busy = 0; tx_done = 0; mstage = 0;
      end else begin
        case (mstage)
          0: if (st) begin
               if (done_first) begin tx_done = 1; mstage = 2; end
               else begin tx_busy = 1; mleft = busy_len; mstage = 1; end
             end
          1: if (mleft == 0) begin tx_busy = 0; tx_done = 1; mstage = 2; end
             else mleft--;
          default: begin tx_done = 0; mstage = 0; end
        endcase
      end
    end
  end

  // Monitor: checks accept rules, pops the scoreboard on every tx_start, times watchdog pulses.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (req_ready != 4'b0) begin
        checks++;
        if (!$onehot(req_ready) || ((req_ready & ~req_valid) != 4'b0) || !tx_en || active) begin
          errors++;
          $display("FAIL accept_rules: req_ready=%b req_valid=%b tx_en=%b active=%b (required onehot subset of valid, tx_en=1, idle)",
                   req_ready, req_valid, tx_en, active);
        end
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (tx_start) begin
        n_start++;
        checks++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: data_out=%h grant_id=%0d with no byte expected", data_out, grant_id);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if (data_out !== e.data || grant_id !== e.id || (cyc - a) != 2 || active !== 1'b1) begin
            errors++;
            $display("FAIL byte_start: data=%h id=%0d latency=%0d active=%b, required data=%h id=%0d latency=2 active=1",
                     data_out, grant_id, cyc - a, active, e.data, e.id);
          end
        end
        last_start = cyc;
      end
      if (timeout_err) begin
        n_to++;
        checks++;
        if (!to_allowed || (cyc - last_start) != 100) begin
          errors++;
          $display("FAIL timeout_pulse: pulse %0d cycles after start (allowed=%0d), required 100", cyc - last_start, to_allowed);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] id);
    exp_t e;
    e.data = d; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    for (int i = 0; i < 400; i++) begin
      if (n_acc >= target) break;
      tick();
    end
    check({name, "_accepts"}, n_acc, target);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if (!active && !tx_busy && !tx_done) break;
      tick();
    end
    check({name, "_idle"}, {31'b0, active}, 32'b0);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0; tick();
  endtask

  initial begin
    int a0, s0;
    rst = 1; tx_en = 0; req_valid = 4'b0; req_data = 32'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_ready, tx_start, data_out, grant_id, active, timeout_err}, 32'b0);
    tick(); rst = 0; tick();

    // 1: single requester
    tx_en = 1; req_data = 32'h0000_0055; push(8'h55, 2'd0);
    req_valid = 4'b0001; wait_acc(n_acc + 1, "t1"); req_valid = 4'b0;
    wait_idle("t1");
    check("t1_grant_id", {30'b0, grant_id}, 32'd0);

    // 2: all four compete from rr_ptr=0
    do_reset();
    req_data = 32'hA3A2_A1A0;
    push(8'hA0, 2'd0); push(8'hA1, 2'd1); push(8'hA2, 2'd2); push(8'hA3, 2'd3); push(8'hA0, 2'd0);
    req_valid = 4'b1111; wait_acc(n_acc + 5, "t2"); req_valid = 4'b0;
    wait_idle("t2");

    // 3: move rr_ptr to 3, then wrap 3 -> 0; uart_tx reports done without busy
    done_first = 1;
    req_data = 32'hC3C2_C1C0; push(8'hC2, 2'd2);
    req_valid = 4'b0100; wait_acc(n_acc + 1, "t3a"); req_valid = 4'b0;
    wait_idle("t3a");
    push(8'hC3, 2'd3); push(8'hC0, 2'd0);
    req_valid = 4'b1001; wait_acc(n_acc + 2, "t3b"); req_valid = 4'b0;
    wait_idle("t3b");
    done_first = 0;

    // 4: tx_en low blocks grants; dropping it mid-byte lets the byte finish
    tx_en = 0; req_data = 32'h005A_3C00; a0 = n_acc; s0 = n_start;
    req_valid = 4'b0010; repeat (20) tick();
    check("t4_blocked", {n_acc - a0, n_start - s0}, 32'b0);
    push(8'h3C, 2'd1); tx_en = 1;
    wait_acc(a0 + 1, "t4a"); tx_en = 0; req_valid = 4'b0100;
    wait_idle("t4a"); repeat (20) tick();
    check("t4_no_regrant", n_acc, a0 + 1);
    push(8'h5A, 2'd2); tx_en = 1;
    wait_acc(a0 + 2, "t4b"); req_valid = 4'b0;
    wait_idle("t4b");

    // 5: reset while waiting for done
    busy_len = 30; req_data = 32'h7700_0000; push(8'h77, 2'd3);
    req_valid = 4'b1000; wait_acc(n_acc + 1, "t5"); req_valid = 4'b0;
    for (int i = 0; i < 50 && dut.state != WAIT_DONE; i++) tick();
    check("t5_reached_wait_done", {29'b0, dut.state}, {29'b0, WAIT_DONE});
    rst = 1;
    @(negedge clk);
    check("t5_reset_outputs", {req_ready, tx_start, data_out, grant_id, active, timeout_err}, 32'b0);
    check("t5_reset_state", {27'b0, dut.state, dut.rr_ptr}, 32'b0);
    tick(); rst = 0; busy_len = 3; tick();
    wait_idle("t5_release");
    req_data = 32'h0000_00FF; push(8'hFF, 2'd0);
    req_valid = 4'b0001; wait_acc(n_acc + 1, "t5b"); req_valid = 4'b0;
    wait_idle("t5b");

`ifdef UART_ARB_TIMEOUT_EN
    // 6: uart_tx never answers; each byte ends on the watchdog and the next requester follows
    model_off = 1; to_allowed = 1;
    req_data = 32'h0000_2211; push(8'h22, 2'd1); push(8'h11, 2'd0);
    req_valid = 4'b0011; wait_acc(n_acc + 1, "t6a"); req_valid = 4'b0001;
    wait_acc(n_acc + 1, "t6b"); req_valid = 4'b0;
    for (int i = 0; i < 300 && active; i++) tick();
    tick();
    to_allowed = 0; model_off = 0;
    check("t6_timeouts", n_to, 2);
`else
    check("no_timeouts", n_to, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
